// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU sequencer: opcode and FSM state encodings plus
// the opcode classification helpers used by the response logic.
package alu_seq_pkg;

    typedef enum logic [3:0] {
        OP_ADC = 4'd0,
        OP_SBC = 4'd1,
        OP_AND = 4'd2,
        OP_ORA = 4'd3,
        OP_EOR = 4'd4,
        OP_LSR = 4'd5,
        OP_ROR = 4'd6,
        OP_ASL = 4'd7,
        OP_ROL = 4'd8,
        OP_CMP = 4'd9,
        OP_INC = 4'd10,
        OP_DEC = 4'd11
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_ADJUST,
        ST_DONE
    } state_t;

    localparam logic [3:0] OP_ILLEGAL_MIN = 4'd12;

    function automatic logic op_updates_c(op_t op);
        return op inside {OP_ADC, OP_SBC, OP_CMP, OP_ASL, OP_ROL, OP_LSR, OP_ROR};
    endfunction

    function automatic logic op_is_arith(op_t op);
        return op inside {OP_ADC, OP_SBC};
    endfunction

endpackage

// File: rtl/alu_sequencer_decimal_corr.sv
// Decimal-correction addend for the second ALU pass, derived from the
// binary pass-1 result and its nibble/byte carries.
module alu_decimal_corr
    import alu_seq_pkg::*;
(
    input  op_t        op,
    input  logic [7:0] res,
    input  logic       hc,
    input  logic       acr,
    output logic [7:0] addend,
    output logic       need_adjust
);

    logic [3:0] lo_corr;
    logic [3:0] hi_corr;
    logic [4:0] lo_sum;
    logic       lo_wrap;

    always_comb begin
        lo_corr = 4'h0;
        hi_corr = 4'h0;
        case (op)
            OP_ADC: begin
                lo_corr = hc  ? 4'h6 : 4'h0;
                hi_corr = acr ? 4'h6 : 4'h0;
            end
            OP_SBC: begin
                lo_corr = hc  ? 4'h0 : 4'hA;
                hi_corr = acr ? 4'h0 : 4'hA;
            end
            default: ;
        endcase
    end

    // The low-nibble add in pass 2 carries into the high nibble when it wraps,
    // so that carry is pre-subtracted from the high correction.
    assign lo_sum      = {1'b0, res[3:0]} + {1'b0, lo_corr};
    assign lo_wrap     = lo_sum[4];
    assign addend      = {hi_corr - {3'b000, lo_wrap}, lo_corr};
    assign need_adjust = |addend;

endmodule

// File: rtl/alu_sequencer.sv
// Sequences the 8-bit ALU through a binary pass and an optional decimal
// correction pass per request, returning the result byte and NVZC flags.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [3:0]    req_op,
    input  logic [DW-1:0] req_a,
    input  logic [DW-1:0] req_b,
    input  logic          req_c,
    input  logic          req_d,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic          alu_addc,
    output logic          alu_daa,
    output logic          alu_sums,
    output logic          alu_ands,
    output logic          alu_ors,
    output logic          alu_eors,
    output logic          alu_srs,
    input  logic [DW-1:0] alu_out,
    input  logic          alu_acr,
    input  logic          alu_hc,
    input  logic          alu_avr,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_n,
    output logic          rsp_v,
    output logic          rsp_z,
    output logic          rsp_c,
    output logic          rsp_wr,
    output logic          rsp_v_upd,
    output logic          rsp_c_upd,
    output logic          rsp_err
);

    state_t        state, state_nxt;
    op_t           op_q;
    logic [DW-1:0] a_q, b_q, res_q, addend_q;
    logic          c_q, d_q, acr_q, avr_q, err_q;
    logic [DW-1:0] addend;
    logic          need_adjust;
    logic          req_illegal;

    assign req_illegal = (req_op >= OP_ILLEGAL_MIN);
    assign req_ready   = (state == ST_IDLE);

    // Fed from the live ALU outputs so the EXEC exit decision is same-cycle.
    alu_decimal_corr u_corr (
        .op          (op_q),
        .res         (alu_out),
        .hc          (alu_hc),
        .acr         (alu_acr),
        .addend      (addend),
        .need_adjust (need_adjust)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            op_q     <= OP_ADC;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= 1'b0;
            d_q      <= 1'b0;
            res_q    <= '0;
            addend_q <= '0;
            acr_q    <= 1'b0;
            avr_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: if (req_valid) begin
                    op_q  <= op_t'(req_op);
                    a_q   <= req_a;
                    b_q   <= req_b;
                    c_q   <= req_c;
                    d_q   <= req_d;
                    err_q <= req_illegal;
                    res_q <= req_a;
                end
                ST_EXEC: begin
                    res_q    <= alu_out;
                    acr_q    <= alu_acr;
                    avr_q    <= alu_avr;
                    addend_q <= addend;
                end
                ST_ADJUST: res_q <= alu_out;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (req_valid) state_nxt = req_illegal ? ST_DONE : ST_EXEC;
            ST_EXEC:   state_nxt = (d_q && need_adjust) ? ST_ADJUST : ST_DONE;
            ST_ADJUST: state_nxt = ST_DONE;
            ST_DONE:   if (rsp_ready) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        alu_a    = '0;
        alu_b    = '0;
        alu_addc = 1'b0;
        alu_daa  = 1'b0;
        alu_sums = 1'b0;
        alu_ands = 1'b0;
        alu_ors  = 1'b0;
        alu_eors = 1'b0;
        alu_srs  = 1'b0;
        case (state)
            ST_EXEC: begin
                alu_a = a_q;
                case (op_q)
                    OP_ADC: begin alu_b = b_q;  alu_addc = c_q; alu_daa = d_q; alu_sums = 1'b1; end
                    OP_SBC: begin alu_b = ~b_q; alu_addc = c_q; alu_sums = 1'b1; end
                    OP_CMP: begin alu_b = ~b_q; alu_addc = 1'b1; alu_sums = 1'b1; end
                    OP_AND: begin alu_b = b_q;  alu_ands = 1'b1; end
                    OP_ORA: begin alu_b = b_q;  alu_ors  = 1'b1; end
                    OP_EOR: begin alu_b = b_q;  alu_eors = 1'b1; end
                    OP_ASL: begin alu_b = a_q;  alu_sums = 1'b1; end
                    OP_ROL: begin alu_b = a_q;  alu_addc = c_q; alu_sums = 1'b1; end
                    OP_LSR: begin alu_srs = 1'b1; end
                    OP_ROR: begin alu_addc = c_q; alu_srs = 1'b1; end
                    OP_INC: begin alu_addc = 1'b1; alu_sums = 1'b1; end
                    OP_DEC: begin alu_b = '1;   alu_sums = 1'b1; end
                    default: ;
                endcase
            end
            ST_ADJUST: begin
                alu_a    = res_q;
                alu_b    = addend_q;
                alu_sums = 1'b1;
            end
            default: ;
        endcase
    end

    // Flags come only from registered state so they hold under backpressure.
    always_comb begin
        rsp_valid = 1'b0;
        rsp_data  = '0;
        rsp_n     = 1'b0;
        rsp_z     = 1'b0;
        rsp_c     = 1'b0;
        rsp_v     = 1'b0;
        rsp_wr    = 1'b0;
        rsp_c_upd = 1'b0;
        rsp_v_upd = 1'b0;
        rsp_err   = 1'b0;
        if (state == ST_DONE) begin
            rsp_valid = 1'b1;
            rsp_data  = res_q;
            rsp_n     = res_q[DW-1];
            rsp_z     = (res_q == '0);
            rsp_err   = err_q;
            if (!err_q) begin
                rsp_wr    = (op_q != OP_CMP);
                rsp_c_upd = op_updates_c(op_q);
                rsp_v_upd = op_is_arith(op_q);
                rsp_c     = acr_q & op_updates_c(op_q);
                rsp_v     = avr_q & op_is_arith(op_q);
            end
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench: behavioural 6502-style ALU drives the DUT's ALU port; results are
// compared with a BCD/binary arithmetic reference model.
module tb_alu_sequencer;
    import alu_seq_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0, req_ready;
    logic [3:0] req_op = '0;
    logic [7:0] req_a = '0, req_b = '0;
    logic       req_c = 1'b0, req_d = 1'b0;
    logic [7:0] alu_a, alu_b, alu_out;
    logic       alu_addc, alu_daa, alu_sums, alu_ands, alu_ors, alu_eors, alu_srs;
    logic       alu_acr, alu_hc, alu_avr;
    logic       rsp_valid, rsp_ready = 1'b0;
    logic [7:0] rsp_data;
    logic       rsp_n, rsp_v, rsp_z, rsp_c, rsp_wr, rsp_v_upd, rsp_c_upd, rsp_err;

    int errors = 0, checks = 0;
    int sel_cyc = 0, multi_cyc = 0;
    logic [7:0] last_a, last_b;
    logic [4:0] sels;

    always #5 clk = ~clk;

    alu_sequencer #(.DW(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_d(req_d),
        .alu_a(alu_a), .alu_b(alu_b), .alu_addc(alu_addc), .alu_daa(alu_daa),
        .alu_sums(alu_sums), .alu_ands(alu_ands), .alu_ors(alu_ors),
        .alu_eors(alu_eors), .alu_srs(alu_srs),
        .alu_out(alu_out), .alu_acr(alu_acr), .alu_hc(alu_hc), .alu_avr(alu_avr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_n(rsp_n), .rsp_v(rsp_v), .rsp_z(rsp_z), .rsp_c(rsp_c),
        .rsp_wr(rsp_wr), .rsp_v_upd(rsp_v_upd), .rsp_c_upd(rsp_c_upd),
        .rsp_err(rsp_err)
    );

    assign sels = {alu_sums, alu_ands, alu_ors, alu_eors, alu_srs};

    // Behavioural ALU: nibble adder with decimal half/carry thresholds when daa is set.
    logic [4:0] m_lo, m_hi;
    logic       m_hc, m_acr;
    logic [8:0] m_bin;
    always_comb begin
        m_lo  = {1'b0, alu_a[3:0]} + {1'b0, alu_b[3:0]} + {4'b0, alu_addc};
        m_hc  = alu_daa ? (m_lo > 5'd9) : m_lo[4];
        m_hi  = {1'b0, alu_a[7:4]} + {1'b0, alu_b[7:4]} + {4'b0, m_hc};
        m_acr = alu_daa ? (m_hi > 5'd9) : m_hi[4];
        m_bin = {1'b0, alu_a} + {1'b0, alu_b} + {8'b0, alu_addc};
        alu_out = 8'h5A;
        alu_acr = 1'b0;
        alu_hc  = 1'b0;
        alu_avr = 1'b0;
        if (alu_sums) begin
            alu_out = {m_hi[3:0], m_lo[3:0]};
            alu_acr = m_acr;
            alu_hc  = m_hc;
            alu_avr = ~(alu_a[7] ^ alu_b[7]) & (alu_a[7] ^ m_bin[7]);
        end else if (alu_ands) alu_out = alu_a & alu_b;
        else if (alu_ors)  alu_out = alu_a | alu_b;
        else if (alu_eors) alu_out = alu_a ^ alu_b;
        else if (alu_srs) begin
            alu_out = {alu_addc, alu_a[7:1]};
            alu_acr = alu_a[0];
        end
    end

    always @(negedge clk) begin
        if (sels != 5'b0) sel_cyc++;
        if ($countones(sels) > 1) multi_cyc++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int bcd2i(input logic [7:0] x);
        return int'(x[7:4]) * 10 + int'(x[3:0]);
    endfunction

    function automatic logic [7:0] i2bcd(input int x);
        return {4'(x / 10), 4'(x % 10)};
    endfunction

    function automatic logic ovf(input logic [7:0] a, input logic [7:0] b, input logic [7:0] s);
        return (a[7] == b[7]) && (s[7] != a[7]);
    endfunction

    task automatic ref_model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                             input logic c, input logic d,
                             output logic [7:0] data, output logic cf, output logic vf,
                             output logic wr, output logic cu, output logic vu, output logic err);
        logic [8:0] s;
        int t;
        data = a; cf = 1'b0; vf = 1'b0; wr = 1'b1; cu = 1'b0; vu = 1'b0; err = 1'b0;
        case (op)
            4'd0, 4'd1: begin
                logic [7:0] bb;
                bb = (op == 4'd0) ? b : ~b;
                s  = {1'b0, a} + {1'b0, bb} + {8'b0, c};
                vf = ovf(a, bb, s[7:0]);
                cu = 1'b1; vu = 1'b1;
                if (!d) begin
                    data = s[7:0]; cf = s[8];
                end else if (op == 4'd0) begin
                    t = bcd2i(a) + bcd2i(b) + int'(c);
                    cf = (t >= 100); data = i2bcd(t % 100);
                end else begin
                    t = bcd2i(a) - bcd2i(b) - int'(!c);
                    cf = (t >= 0); data = i2bcd(t < 0 ? t + 100 : t);
                end
            end
            4'd2: data = a & b;
            4'd3: data = a | b;
            4'd4: data = a ^ b;
            4'd5: begin data = a >> 1; cf = a[0]; cu = 1'b1; end
            4'd6: begin data = {c, a[7:1]}; cf = a[0]; cu = 1'b1; end
            4'd7: begin data = a << 1; cf = a[7]; cu = 1'b1; end
            4'd8: begin data = {a[6:0], c}; cf = a[7]; cu = 1'b1; end
            4'd9: begin data = a - b; cf = (a >= b); cu = 1'b1; wr = 1'b0; end
            4'd10: data = a + 8'd1;
            4'd11: data = a - 8'd1;
            default: begin wr = 1'b0; err = 1'b1; end
        endcase
    endtask

    task automatic do_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic c, input logic d, input int hold, input int exp_lat);
        logic [7:0] e_data;
        logic e_c, e_v, e_wr, e_cu, e_vu, e_err;
        int lat, budget, s0, m0;
        ref_model(op, a, b, c, d, e_data, e_c, e_v, e_wr, e_cu, e_vu, e_err);
        @(negedge clk);
        budget = 0;
        while (!req_ready && budget < 20) begin @(negedge clk); budget++; end
        chk("req_ready_idle", req_ready, 1);
        req_op = op; req_a = a; req_b = b; req_c = c; req_d = d; req_valid = 1'b1;
        s0 = sel_cyc; m0 = multi_cyc;
        @(posedge clk); #1 req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 10) begin
            if (sels != 5'b0) begin last_a = alu_a; last_b = alu_b; end
            @(posedge clk); #1;
            lat++;
        end
        chk("rsp_valid", rsp_valid, 1);
        if (exp_lat > 0) chk("latency", lat, exp_lat);
        chk("data", rsp_data, e_data);
        chk("err", rsp_err, e_err);
        chk("wr", rsp_wr, e_wr);
        chk("c_upd", rsp_c_upd, e_cu);
        chk("v_upd", rsp_v_upd, e_vu);
        if (!e_err) begin
            chk("n", rsp_n, e_data[7]);
            chk("z", rsp_z, e_data == 8'h00);
        end
        if (e_cu) chk("c", rsp_c, e_c);
        if (e_vu) chk("v", rsp_v, e_v);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", rsp_valid, 1);
            chk("hold_data", rsp_data, e_data);
            chk("hold_req_ready", req_ready, 0);
        end
        @(negedge clk);
        chk("sel_cycles", sel_cyc - s0, lat - 1);
        chk("sel_onehot", multi_cyc - m0, 0);
        rsp_ready = 1'b1;
        @(posedge clk); #1 rsp_ready = 1'b0;
        chk("rsp_valid_after", rsp_valid, 0);
        chk("req_ready_after", req_ready, 1);
    endtask

    initial begin
        int cnt;
        logic [3:0] op;
        logic [7:0] a, b;
        logic c, d;

        repeat (2) @(negedge clk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_sels", sels, 0);
        chk("rst_alu_a", alu_a, 0);
        rst_n = 1'b1;

        do_op(4'd0, 8'h50, 8'h50, 1'b0, 1'b0, 5, 2);
        do_op(4'd0, 8'h58, 8'h46, 1'b1, 1'b1, 0, 3);
        chk("adc_dec_pass1", last_a, 8'hAF);
        chk("adc_dec_addend", last_b, 8'h56);
        do_op(4'd1, 8'h12, 8'h21, 1'b1, 1'b1, 0, 3);
        chk("sbc_dec_pass1", last_a, 8'hF1);
        chk("sbc_dec_addend", last_b, 8'hA0);
        do_op(4'd6, 8'h01, 8'h00, 1'b1, 1'b0, 0, 2);
        do_op(4'd9, 8'h40, 8'h40, 1'b0, 1'b0, 0, 2);
        do_op(4'hE, 8'h33, 8'h00, 1'b0, 1'b0, 1, 1);

        // Reset while the binary pass is on the ALU.
        @(negedge clk);
        req_op = 4'd0; req_a = 8'h11; req_b = 8'h22; req_c = 1'b0; req_d = 1'b0;
        req_valid = 1'b1;
        @(posedge clk); #1 req_valid = 1'b0;
        chk("exec_sums", alu_sums, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_req_ready", req_ready, 1);
        chk("midrst_sels", sels, 0);
        chk("midrst_alu_a", alu_a, 0);
        chk("midrst_rsp_valid", rsp_valid, 0);
        @(negedge clk) rst_n = 1'b1;
        cnt = 0;
        repeat (6) begin @(negedge clk); if (rsp_valid) cnt++; end
        chk("no_rsp_after_rst", cnt, 0);

        for (int i = 0; i < 150; i++) begin
            op = 4'($urandom_range(15, 0));
            c  = 1'($urandom);
            d  = 1'($urandom);
            a  = 8'($urandom);
            b  = 8'($urandom);
            if (op <= 4'd1 && d) begin
                a = i2bcd(int'($urandom_range(99, 0)));
                b = i2bcd(int'($urandom_range(99, 0)));
            end
            do_op(op, a, b, c, d, int'($urandom_range(2, 0)),
                  (op >= 4'd12) ? 1 : ((op <= 4'd1 && d) ? -1 : 2));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Drives the 8-bit ALU's operand and control inputs and collects its results. Accepts one 6502 arithmetic/logic request per valid/ready handshake and sequences the ALU over 1–2 passes: a binary pass, then a decimal-correction pass when needed. Returns the result byte and NVZC flags to the execute stage over a valid/ready response channel.

Parameters:
- DW, 8, datapath width. Fixed at 8; other values are unsupported.

Ports:
- clk in 1: sole clock, rising edge.
- rst_n in 1: asynchronous, active-low reset.
- req_valid in 1 / req_ready out 1: request handshake.
- req_op in 4: operation code, enumerated in the package.
- req_a in 8: operand A.
- req_b in 8: operand B.
- req_c in 1: carry flag in.
- req_d in 1: decimal flag in.
- alu_a out 8 / alu_b out 8 / alu_addc out 1 / alu_daa out 1: ALU operands, carry-in and decimal-adjust enable.
- alu_sums, alu_ands, alu_ors, alu_eors, alu_srs out 1 each: ALU one-hot output select.
- alu_out in 8, alu_acr in 1, alu_hc in 1, alu_avr in 1: ALU results.
- rsp_valid out 1 / rsp_ready in 1: response handshake.
- rsp_data out 8: result byte.
- rsp_n, rsp_v, rsp_z, rsp_c out 1 each: flags.
- rsp_wr out 1: result is to be written back.
- rsp_v_upd, rsp_c_upd out 1 each: V/C are to be updated.
- rsp_err out 1: illegal opcode.

Behaviour:
- Reset state:
  - State IDLE; req_ready=1.
  - All other outputs 0, including every ALU select.
  - Asserting rst_n low mid-operation discards the operation, with no response.
- States: IDLE, EXEC, ADJUST, DONE.
- IDLE:
  - req_ready=1 only in this state.
  - On req_valid, register op/a/b/c/d and go to EXEC.
  - An illegal op (12–15) goes straight to DONE with rsp_err=1, rsp_data=req_a, and all *_upd/wr=0.
- EXEC (one cycle): exactly one select is high; capture alu_out/acr/hc/avr at the clock edge. Per-op drive:
  - ADC: a, b, addc=C, daa=D, sums.
  - SBC: a, ~b, addc=C, daa=0, sums.
  - CMP: a, ~b, addc=1, sums, wr=0.
  - AND / ORA / EOR: a, b, ands / ors / eors.
  - ASL: a, a, addc=0, sums.
  - ROL: a, a, addc=C, sums.
  - LSR: a, addc=0, srs.
  - ROR: a, addc=C, srs.
  - INC: a, 0x00, addc=1, sums.
  - DEC: a, 0xFF, addc=0, sums.
- Exit from EXEC:
  - ADC/SBC with D=1 and nonzero correction go to ADJUST; everything else goes to DONE.
- Decimal correction:
  - ADC: lo_corr=6 if hc, hi_corr=6 if acr.
  - SBC: lo_corr=0xA if !hc, hi_corr=0xA if !acr.
  - lo_wrap = (result[3:0] + lo_corr > 0xF).
  - Addend = {hi_corr − lo_wrap, lo_corr}, 4-bit modular per nibble.
- ADJUST (one cycle): a = pass-1 result, b = addend, addc=0, daa=0, sums. Capture alu_out only; acr from this pass is ignored.
- Flags:
  - N = data[7]; Z = (data==0).
  - C = pass-1 acr for ADC/SBC/CMP/shifts/rotates.
  - V = pass-1 avr for ADC/SBC only.
  - c_upd=1 for ADC/SBC/CMP/ASL/ROL/LSR/ROR.
  - v_upd=1 for ADC/SBC.
  - wr=1 except for CMP.
- Select lines are all 0 outside EXEC/ADJUST. alu_out is never sampled there.
- DONE:
  - rsp_valid=1; rsp_* are held stable until rsp_ready.
  - On the handshake, go to IDLE.
  - No same-cycle accept: req_ready rises the cycle after the handshake.
- Latency from accept edge to rsp_valid:
  - 2 cycles for binary ops.
  - 3 cycles for decimal ops with correction.
  - 1 cycle for illegal ops.
- Throughput: at most one operation in flight.

Decomposition:
- alu_seq_pkg:
  - op enum: ADC=0, SBC, AND, ORA, EOR, LSR, ROR, ASL, ROL, CMP, INC, DEC=11.
  - state enum.
  - OP_ILLEGAL_MIN=12.
- Sub-module alu_decimal_corr: combinational; inputs op, pass-1 result, hc, acr; outputs addend and need_adjust.

Test Plan:
- ADC binary: a=0x50, b=0x50, C=0, D=0 → data=0xA0, N=1, V=1, C=0, Z=0; rsp_valid 2 cycles after accept.
- ADC decimal: a=0x58, b=0x46, C=1, D=1 → pass-1 result 0xAF, ADJUST alu_b=0x56, data=0x05, C=1; 3-cycle latency.
- SBC decimal: a=0x12, b=0x21, C=1, D=1 → pass-1 result 0xF1, ADJUST alu_b=0xA0, data=0x91, C=0, N=1.
- ROR: a=0x01, C=1 → data=0x80, C=1, N=1, alu_srs high only in EXEC. Then CMP a=0x40, b=0x40 → Z=1, C=1, wr=0, v_upd=0.
- Illegal op 0xE with a=0x33 → rsp_err=1, data=0x33, 1-cycle latency, no ALU select ever high.
- Backpressure and reset:
  - Hold rsp_ready=0 for 5 cycles → rsp_* stable and req_ready=0 throughout.
  - Drop rst_n during EXEC → outputs 0 immediately and req_ready=1.
  - No response is produced after release.
